// File: rtl/vcve2_vmem_sequencer.sv
// Vector memory sequencer: splits one vector load/store command into a series
// of 32-bit word accesses on an OBI-style request port. It feeds store words
// from the VRF read path and returns load words to the VRF write path.
// Optional feature macro: VCVE2_VMEM_STRIDE_EN. When it is defined, the
// address step is the latched command stride. When it is undefined, the step
// is a fixed +4 (unit stride).
module vcve2_vmem_sequencer #(
  parameter int MAX_WORDS       = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int NW             = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [31:0]   cmd_addr_i,
  input  logic [31:0]   cmd_stride_i,
  input  logic [NW-1:0] cmd_nwords_i,
  input  logic          st_valid_i,
  output logic          st_ready_o,
  input  logic [31:0]   st_data_i,
  output logic          ld_valid_o,
  output logic [NW-1:0] ld_idx_o,
  output logic [31:0]   ld_data_o,
  output logic          done_o,
  output logic          err_o,
  output logic          data_req_o,
  input  logic          data_gnt_i,
  input  logic          data_rvalid_i,
  output logic          data_we_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_addr_o,
  output logic [31:0]   data_wdata_o,
  input  logic [31:0]   data_rdata_i,
  input  logic          data_err_i
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          we_q, err_q;
  logic [31:0]   addr_q;
  logic [NW-1:0] nwords_q, iss_q, rcv_q;
  logic [OW-1:0] os_q;
  logic          ld_valid_q;
  logic [NW-1:0] ld_idx_q;
  logic [31:0]   ld_data_q;

  logic          accept, req, grant, rv_ok, last_grant;
  logic signed [31:0] addr_step;

  assign accept     = cmd_valid_i && (state_q == S_IDLE);
  // A request is raised only while issuing. It is not raised after an error
  // or while the outstanding window is full. A store also needs a word ready.
  assign req        = (state_q == S_ISSUE) && !err_q && (os_q < MAX_OS) &&
                      (!we_q || st_valid_i);
  assign grant      = req && data_gnt_i;
  // Stray responses, for example ones left over after a reset, are dropped.
  // Dropping them keeps the outstanding counter from underflowing.
  assign rv_ok      = data_rvalid_i && (os_q != '0);
  assign last_grant = grant && (iss_q == nwords_q - 1'b1);

`ifdef VCVE2_VMEM_STRIDE_EN
  logic signed [31:0] stride_q;
  assign addr_step = stride_q;

  // Latch the word-aligned stride with the command
  always_ff @(posedge clk_i) begin
    if (rst_i)       stride_q <= '0;
    else if (accept) stride_q <= {cmd_stride_i[31:2], 2'b00};
  end
`else
  assign addr_step = 32'sd4;
`endif

  // Bits that do not affect behaviour in every build
  logic unused_bits;
  assign unused_bits = ^{cmd_addr_i[1:0], cmd_stride_i};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (cmd_nwords_i == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_grant || err_q) state_d = S_DRAIN;
      S_DRAIN: if (os_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, address walk, index counters and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      nwords_q <= '0;
      iss_q    <= '0;
      rcv_q    <= '0;
    end else if (accept) begin
      we_q     <= cmd_we_i;
      err_q    <= 1'b0;
      addr_q   <= {cmd_addr_i[31:2], 2'b00};
      nwords_q <= cmd_nwords_i;
      iss_q    <= '0;
      rcv_q    <= '0;
    end else begin
      if (grant) begin
        addr_q <= addr_q + $unsigned(addr_step);
        iss_q  <= iss_q + 1'b1;
      end
      if (rv_ok) begin
        rcv_q <= rcv_q + 1'b1;
        if (data_err_i) err_q <= 1'b1;
      end
    end
  end

  // Outstanding transaction count. A grant and a response in the same cycle
  // cancel each other out.
  always_ff @(posedge clk_i) begin
    if (rst_i) os_q <= '0;
    else if (grant && !rv_ok) os_q <= os_q + 1'b1;
    else if (!grant && rv_ok) os_q <= os_q - 1'b1;
  end

  // Load return path. It is registered one cycle after the response, and
  // responses that carry an error are not delivered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_valid_q <= 1'b0;
      ld_idx_q   <= '0;
      ld_data_q  <= '0;
    end else begin
      ld_valid_q <= rv_ok && !we_q && !data_err_i;
      if (rv_ok) begin
        ld_idx_q  <= rcv_q;
        ld_data_q <= data_rdata_i;
      end
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_DONE) && err_q;
  assign data_req_o   = req;
  assign data_we_o    = we_q;
  assign data_be_o    = req ? 4'b1111 : 4'b0000;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = req ? st_data_i : 32'h0;
  assign st_ready_o   = grant;
  assign ld_valid_o   = ld_valid_q;
  assign ld_idx_o     = ld_idx_q;
  assign ld_data_o    = ld_data_q;

endmodule
